// File: rtl/w_rom_pkg.sv
// Shared types and constants for the weight-ROM read path.
package w_rom_pkg;

   localparam int W_ROM_DEPTH      = 1152;
   localparam int W_ROM_WIDTH      = 32;
   localparam int W_ROM_RD_LATENCY = 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      DRAIN = 2'd2,
      FIN   = 2'd3
   } w_rom_state_e;

endpackage

// File: rtl/w_rom_skid_fifo.sv
// Small synchronous FIFO that absorbs ROM responses while the consumer stalls.
module w_rom_skid_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 2,
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [PTR_W-1:0] wr_ptr_r;
   logic [PTR_W-1:0] rd_ptr_r;
   logic [CNT_W-1:0] count_r;
   logic             push_ok_s;
   logic             pop_ok_s;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      logic [PTR_W-1:0] r;
      if (p == PTR_W'(DEPTH - 1)) begin
         r = '0;
      end else begin
         r = p + PTR_W'(1);
      end
      return r;
   endfunction

   assign full      = (count_r == CNT_W'(DEPTH));
   assign empty     = (count_r == '0);
   assign count     = count_r;
   assign pop_data  = mem_r[rd_ptr_r];
   // A push into a full FIFO is still legal when the head leaves in the same cycle.
   assign push_ok_s = push & (~full | pop);
   assign pop_ok_s  = pop & ~empty;

   // Storage, pointers and occupancy.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= '0;
         end
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         count_r  <= '0;
      end else begin
         if (push_ok_s) begin
            mem_r[wr_ptr_r] <= push_data;
            wr_ptr_r        <= ptr_inc(wr_ptr_r);
         end
         if (pop_ok_s) begin
            rd_ptr_r <= ptr_inc(rd_ptr_r);
         end
         case ({push_ok_s, pop_ok_s})
            2'b10:   count_r <= count_r + CNT_W'(1);
            2'b01:   count_r <= count_r - CNT_W'(1);
            default: count_r <= count_r;
         endcase
      end
   end

endmodule

// File: rtl/w_rom_reader.sv
// Burst read sequencer for the weight ROM: issues reads under a credit limit and
// streams the returned words to the PE array over valid/ready.
module w_rom_reader
   import w_rom_pkg::*;
#(
   parameter int DATA_WIDTH = W_ROM_WIDTH,
   parameter int DATA_DEPTH = W_ROM_DEPTH,
   parameter int ADDR_W     = $clog2(DATA_DEPTH),
   parameter int LEN_W      = $clog2(DATA_DEPTH) + 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [ADDR_W-1:0]     base_addr,
   input  logic [LEN_W-1:0]      burst_len,
   output logic                  busy,
   output logic                  done,
   output logic                  rom_cen_b,
   output logic [ADDR_W-1:0]     rom_addr,
   input  logic [DATA_WIDTH-1:0] rom_q,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_valid,
   input  logic                  out_ready
);

   // One buffer slot per in-flight read plus the head keeps full rate under backpressure.
   localparam int SKID_DEPTH = W_ROM_RD_LATENCY + 1;
   localparam int CNT_W      = $clog2(SKID_DEPTH + 1);
   localparam int OCC_W      = CNT_W + 1;

   w_rom_state_e      state_r;
   w_rom_state_e      state_nxt_s;
   logic [LEN_W-1:0]  len_r;
   logic [LEN_W-1:0]  issue_cnt_r;
   logic [LEN_W-1:0]  acc_cnt_r;
   logic [LEN_W-1:0]  issue_total_s;
   logic [LEN_W-1:0]  acc_total_s;
   logic [ADDR_W-1:0] next_addr_r;
   logic [ADDR_W-1:0] last_addr_r;
   logic [ADDR_W-1:0] cur_addr_s;
   logic              pend_r;
   logic              issue_s;
   logic              pop_s;
   logic              credit_ok_s;
   logic              fifo_full_s;
   logic              fifo_empty_s;
   logic [CNT_W-1:0]  fifo_count_s;
   logic [OCC_W-1:0]  occ_s;

   function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
      logic [ADDR_W:0] sum;
      sum = {1'b0, a} + (ADDR_W + 1)'(1);
      if (sum >= (ADDR_W + 1)'(DATA_DEPTH)) begin
         sum = sum - (ADDR_W + 1)'(DATA_DEPTH);
      end else begin
         sum = sum;
      end
      return sum[ADDR_W-1:0];
   endfunction

   assign out_valid     = ~fifo_empty_s;
   assign pop_s         = out_valid & out_ready;
   // Words held or in flight after this cycle's transfer; one more read must still fit.
   assign occ_s         = OCC_W'(fifo_count_s) + OCC_W'(pend_r) - OCC_W'(pop_s);
   assign credit_ok_s   = (occ_s < OCC_W'(SKID_DEPTH)) & ~(fifo_full_s & ~pop_s);
   assign cur_addr_s    = (state_r == IDLE) ? base_addr : next_addr_r;
   assign issue_total_s = issue_cnt_r + LEN_W'(issue_s);
   assign acc_total_s   = acc_cnt_r + LEN_W'(pop_s);

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // FSM next-state decode.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            if (start) begin
               state_nxt_s = (burst_len == '0) ? FIN : FETCH;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         FETCH: begin
            if (issue_total_s == len_r) begin
               state_nxt_s = DRAIN;
            end else begin
               state_nxt_s = FETCH;
            end
         end
         DRAIN: begin
            if (acc_total_s == len_r) begin
               state_nxt_s = FIN;
            end else begin
               state_nxt_s = DRAIN;
            end
         end
         FIN:     state_nxt_s = IDLE;
         default: state_nxt_s = IDLE;
      endcase
   end

   // FSM outputs; the first read goes out in the start cycle to meet the 2-cycle latency.
   always_comb begin
      issue_s = 1'b0;
      busy    = 1'b0;
      done    = 1'b0;
      case (state_r)
         IDLE: begin
            issue_s = start & (burst_len != '0) & credit_ok_s;
         end
         FETCH: begin
            busy    = 1'b1;
            issue_s = (issue_cnt_r < len_r) & credit_ok_s;
         end
         DRAIN: begin
            busy = 1'b1;
         end
         FIN: begin
            busy = 1'b1;
            done = 1'b1;
         end
         default: begin
            issue_s = 1'b0;
         end
      endcase
      rom_cen_b = ~issue_s;
      rom_addr  = issue_s ? cur_addr_s : last_addr_r;
   end

   // Burst bookkeeping: length, issue/accept counters, address walk, in-flight flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         len_r       <= '0;
         issue_cnt_r <= '0;
         acc_cnt_r   <= '0;
         next_addr_r <= '0;
         last_addr_r <= '0;
         pend_r      <= 1'b0;
      end else begin
         pend_r <= issue_s;
         if (issue_s) begin
            next_addr_r <= addr_inc(cur_addr_s);
            last_addr_r <= cur_addr_s;
         end
         if (state_r == IDLE) begin
            if (start) begin
               len_r <= burst_len;
            end
            issue_cnt_r <= LEN_W'(issue_s);
            acc_cnt_r   <= '0;
         end else begin
            issue_cnt_r <= issue_total_s;
            acc_cnt_r   <= acc_total_s;
         end
      end
   end

   w_rom_skid_fifo #(
      .WIDTH (DATA_WIDTH),
      .DEPTH (SKID_DEPTH),
      .CNT_W (CNT_W)
   ) u_skid (
      .clk       (clk),
      .rst       (rst),
      .push      (pend_r),
      .push_data (rom_q),
      .pop       (pop_s),
      .pop_data  (out_data),
      .full      (fifo_full_s),
      .empty     (fifo_empty_s),
      .count     (fifo_count_s)
   );

endmodule

// File: tb/tb_w_rom_reader.sv
// Randomized self-checking bench for w_rom_reader with a behavioural ROM and burst model.
module tb_w_rom_reader;
   import w_rom_pkg::*;

   localparam int DW    = W_ROM_WIDTH;
   localparam int DEPTH = W_ROM_DEPTH;
   localparam int AW    = $clog2(DEPTH);
   localparam int LW    = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [AW-1:0] base_addr;
   logic [LW-1:0] burst_len;
   logic          busy;
   logic          done;
   logic          rom_cen_b;
   logic [AW-1:0] rom_addr;
   logic [DW-1:0] rom_q;
   logic [DW-1:0] out_data;
   logic          out_valid;
   logic          out_ready;

   w_rom_reader dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .base_addr (base_addr),
      .burst_len (burst_len),
      .busy      (busy),
      .done      (done),
      .rom_cen_b (rom_cen_b),
      .rom_addr  (rom_addr),
      .rom_q     (rom_q),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   always #5 clk = ~clk;

   // Behavioural ROM macro: 1-cycle read latency.
   logic [DW-1:0] rom_mem [DEPTH];
   always @(posedge clk) begin
      if (!rom_cen_b) rom_q <= rom_mem[rom_addr];
   end

   int pass_cnt  = 0;
   int total_cnt = 0;

   logic [DW-1:0] got_data [$];
   int            got_addr [$];
   int first_valid_cyc, last_valid_cyc, done_cnt, done_cyc;
   int busy_first, busy_last, busy_cnt, max_out, stall_bad, timed_out;
   int post_rst_valid, post_rst_issue;
   logic          rs_busy, rs_done, rs_cen_b, rs_valid;
   logic [AW-1:0] rs_addr;
   logic [DW-1:0] rs_data;

   // Model: word i of a burst lives at (base + i) mod DEPTH.
   function automatic int data_errs(input int base, input int len);
      int e = 0;
      if (got_data.size() != len) e++;
      for (int i = 0; i < got_data.size() && i < len; i++)
         if (got_data[i] !== rom_mem[(base + i) % DEPTH]) e++;
      return e;
   endfunction

   function automatic int addr_errs(input int base, input int len);
      int e = 0;
      if (got_addr.size() != len) e++;
      for (int i = 0; i < got_addr.size() && i < len; i++)
         if (got_addr[i] != (base + i) % DEPTH) e++;
      return e;
   endfunction

   // Drives one burst and records what the DUT did; cycle 0 is the start cycle.
   // mode: 0 ready always high, 1 ready pattern 1,0,0,..., 2 random ready.
   task automatic run_burst(input int base, input int len, input int mode,
                            input int abort_at, input bit poke);
      int issued = 0;
      int xfer = 0;
      int tail = -1;
      bit fin = 1'b0;
      bit prev_stall = 1'b0;
      logic [DW-1:0] prev_data = '0;
      got_data.delete();
      got_addr.delete();
      first_valid_cyc = -1; last_valid_cyc = -1; done_cnt = 0; done_cyc = -1;
      busy_first = -1; busy_last = -1; busy_cnt = 0; max_out = 0; stall_bad = 0;
      timed_out = 0; post_rst_valid = 0; post_rst_issue = 0;
      for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
         @(negedge clk);
         start     = (cyc == 0) || (poke && (cyc == 2 || cyc == 4));
         base_addr = (cyc == 0) ? AW'(base) : AW'((base + 37) % DEPTH);
         burst_len = (cyc == 0) ? LW'(len) : LW'(3);
         case (mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ((cyc % 3) == 0);
            default: out_ready = 1'($urandom_range(0, 1));
         endcase
         #1;
         if (!rom_cen_b) begin
            got_addr.push_back(int'(rom_addr));
            issued++;
         end
         if (prev_stall && (!out_valid || out_data !== prev_data)) stall_bad++;
         if (out_valid) begin
            if (first_valid_cyc < 0) first_valid_cyc = cyc;
            last_valid_cyc = cyc;
         end
         if (out_valid && out_ready) begin
            got_data.push_back(out_data);
            xfer++;
         end
         if (issued - xfer > max_out) max_out = issued - xfer;
         prev_stall = out_valid && !out_ready;
         prev_data  = out_data;
         if (busy) begin
            if (busy_first < 0) busy_first = cyc;
            busy_last = cyc;
            busy_cnt++;
         end
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
            if (tail < 0) tail = 3;
         end
         if (tail > 0) begin
            tail--;
            if (tail == 0) fin = 1'b1;
         end
         if (abort_at >= 0 && xfer == abort_at) begin
            start = 1'b0;
            #1 rst = 1'b1;
            #1;
            rs_busy = busy; rs_done = done; rs_cen_b = rom_cen_b;
            rs_addr = rom_addr; rs_valid = out_valid; rs_data = out_data;
            @(negedge clk);
            rst = 1'b0;
            for (int k = 0; k < 4; k++) begin
               @(negedge clk);
               #1;
               if (done) done_cnt++;
               if (out_valid) post_rst_valid++;
               if (!rom_cen_b) post_rst_issue++;
            end
            fin = 1'b1;
         end
      end
      if (!fin) timed_out = 1;
      start = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; out_ready = 1'b0; base_addr = '0; burst_len = '0;
      repeat (2) @(posedge clk);
      #1;
      total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else pass_cnt++;
      total_cnt++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else pass_cnt++;
      total_cnt++; if (rom_cen_b !== 1'b1) $display("FAIL reset_cen_b got %b want 1", rom_cen_b); else pass_cnt++;
      total_cnt++; if (rom_addr !== '0) $display("FAIL reset_addr got %0d want 0", rom_addr); else pass_cnt++;
      total_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", out_valid); else pass_cnt++;
      total_cnt++; if (out_data !== '0) $display("FAIL reset_data got %h want 0", out_data); else pass_cnt++;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_basic();
      int e;
      run_burst(0, 4, 0, -1, 1'b0);
      total_cnt++; if (timed_out != 0) $display("FAIL basic_timeout got %0d want 0", timed_out); else pass_cnt++;
      e = addr_errs(0, 4);
      total_cnt++; if (e != 0) $display("FAIL basic_addr errors %0d want 0", e); else pass_cnt++;
      e = data_errs(0, 4);
      total_cnt++; if (e != 0) $display("FAIL basic_data errors %0d want 0", e); else pass_cnt++;
      total_cnt++; if (first_valid_cyc != 2) $display("FAIL basic_first_valid got %0d want 2", first_valid_cyc); else pass_cnt++;
      total_cnt++; if (last_valid_cyc != 5) $display("FAIL basic_last_valid got %0d want 5", last_valid_cyc); else pass_cnt++;
      total_cnt++; if (done_cyc != 6) $display("FAIL basic_done_cyc got %0d want 6", done_cyc); else pass_cnt++;
      total_cnt++; if (done_cnt != 1) $display("FAIL basic_done_cnt got %0d want 1", done_cnt); else pass_cnt++;
      total_cnt++; if (busy_first != 1 || busy_last != 6 || busy_cnt != 6)
         $display("FAIL basic_busy got %0d..%0d (%0d) want 1..6 (6)", busy_first, busy_last, busy_cnt);
      else pass_cnt++;
   endtask

   task automatic test_wrap();
      int e;
      run_burst(1150, 4, 0, -1, 1'b0);
      e = addr_errs(1150, 4);
      total_cnt++; if (e != 0) $display("FAIL wrap_addr errors %0d want 0", e); else pass_cnt++;
      e = data_errs(1150, 4);
      total_cnt++; if (e != 0) $display("FAIL wrap_data errors %0d want 0", e); else pass_cnt++;
      total_cnt++; if (done_cnt != 1) $display("FAIL wrap_done_cnt got %0d want 1", done_cnt); else pass_cnt++;
   endtask

   task automatic test_backpressure();
      int e;
      run_burst(10, 8, 1, -1, 1'b0);
      total_cnt++; if (timed_out != 0) $display("FAIL bp_timeout got %0d want 0", timed_out); else pass_cnt++;
      total_cnt++; if (max_out > 2) $display("FAIL bp_outstanding got %0d want <=2", max_out); else pass_cnt++;
      total_cnt++; if (stall_bad != 0) $display("FAIL bp_stall_stable got %0d want 0", stall_bad); else pass_cnt++;
      e = data_errs(10, 8);
      total_cnt++; if (e != 0) $display("FAIL bp_data errors %0d want 0", e); else pass_cnt++;
      e = addr_errs(10, 8);
      total_cnt++; if (e != 0) $display("FAIL bp_addr errors %0d want 0", e); else pass_cnt++;
      total_cnt++; if (done_cnt != 1) $display("FAIL bp_done_cnt got %0d want 1", done_cnt); else pass_cnt++;
   endtask

   task automatic test_zero_len();
      run_burst(55, 0, 0, -1, 1'b0);
      total_cnt++; if (got_addr.size() != 0) $display("FAIL zero_issue got %0d want 0", got_addr.size()); else pass_cnt++;
      total_cnt++; if (busy_first != 1 || busy_cnt != 1)
         $display("FAIL zero_busy got first %0d count %0d want 1 1", busy_first, busy_cnt);
      else pass_cnt++;
      total_cnt++; if (done_cyc != 1 || done_cnt != 1)
         $display("FAIL zero_done got cyc %0d count %0d want 1 1", done_cyc, done_cnt);
      else pass_cnt++;
      total_cnt++; if (first_valid_cyc != -1) $display("FAIL zero_valid got %0d want -1", first_valid_cyc); else pass_cnt++;
   endtask

   task automatic test_reset_mid_burst();
      int e;
      run_burst(20, 8, 0, 3, 1'b0);
      total_cnt++; if (got_data.size() != 3) $display("FAIL abort_words got %0d want 3", got_data.size()); else pass_cnt++;
      total_cnt++; if (rs_busy !== 1'b0 || rs_done !== 1'b0 || rs_valid !== 1'b0)
         $display("FAIL abort_ctrl got busy %b done %b valid %b want 0 0 0", rs_busy, rs_done, rs_valid);
      else pass_cnt++;
      total_cnt++; if (rs_cen_b !== 1'b1 || rs_addr !== '0)
         $display("FAIL abort_rom got cen_b %b addr %0d want 1 0", rs_cen_b, rs_addr);
      else pass_cnt++;
      total_cnt++; if (rs_data !== '0) $display("FAIL abort_data got %h want 0", rs_data); else pass_cnt++;
      total_cnt++; if (done_cnt != 0) $display("FAIL abort_done got %0d want 0", done_cnt); else pass_cnt++;
      total_cnt++; if (post_rst_valid != 0 || post_rst_issue != 0)
         $display("FAIL abort_quiet got valid %0d issue %0d want 0 0", post_rst_valid, post_rst_issue);
      else pass_cnt++;
      run_burst(100, 2, 0, -1, 1'b0);
      e = data_errs(100, 2);
      total_cnt++; if (e != 0) $display("FAIL abort_next_data errors %0d want 0", e); else pass_cnt++;
      total_cnt++; if (done_cnt != 1) $display("FAIL abort_next_done got %0d want 1", done_cnt); else pass_cnt++;
   endtask

   task automatic test_start_while_busy();
      int e;
      run_burst(300, 6, 0, -1, 1'b1);
      e = addr_errs(300, 6);
      total_cnt++; if (e != 0) $display("FAIL busy_start_addr errors %0d want 0", e); else pass_cnt++;
      e = data_errs(300, 6);
      total_cnt++; if (e != 0) $display("FAIL busy_start_data errors %0d want 0", e); else pass_cnt++;
      total_cnt++; if (done_cnt != 1) $display("FAIL busy_start_done got %0d want 1", done_cnt); else pass_cnt++;
      total_cnt++; if (busy_cnt != 8) $display("FAIL busy_start_busy got %0d want 8", busy_cnt); else pass_cnt++;
   endtask

   task automatic test_random();
      int base, len, e;
      for (int n = 0; n < 6; n++) begin
         base = $urandom_range(0, DEPTH - 1);
         len  = $urandom_range(1, 24);
         run_burst(base, len, 2, -1, 1'b0);
         total_cnt++; if (timed_out != 0) $display("FAIL rnd%0d_timeout got %0d want 0", n, timed_out); else pass_cnt++;
         e = data_errs(base, len);
         total_cnt++; if (e != 0) $display("FAIL rnd%0d_data base %0d len %0d errors %0d want 0", n, base, len, e); else pass_cnt++;
         e = addr_errs(base, len);
         total_cnt++; if (e != 0) $display("FAIL rnd%0d_addr base %0d len %0d errors %0d want 0", n, base, len, e); else pass_cnt++;
         total_cnt++; if (max_out > 2) $display("FAIL rnd%0d_outstanding got %0d want <=2", n, max_out); else pass_cnt++;
         total_cnt++; if (stall_bad != 0) $display("FAIL rnd%0d_stall got %0d want 0", n, stall_bad); else pass_cnt++;
         total_cnt++; if (done_cnt != 1) $display("FAIL rnd%0d_done got %0d want 1", n, done_cnt); else pass_cnt++;
      end
   endtask

   initial begin
      for (int k = 0; k < DEPTH; k++) rom_mem[k] = $urandom;
      test_reset();
      test_basic();
      test_wrap();
      test_backpressure();
      test_zero_len();
      test_reset_mid_burst();
      test_start_while_busy();
      test_random();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
